// File: rtl/fetch_controller.sv
// Instruction fetch controller: requests one word at pc, holds it for issue,
// then redirects on branch, J/JAL, or falls through to pc+4 (wraps mod 2^32).
// Ports: clk, reset (async, active-high); imem_req/imem_addr/imem_ack/imem_rdata
// memory side; stall, branch_taken, branch_target from the pipeline; pc, instr,
// instr_valid, fetch_err to the pipeline.
// Optional macro FETCH_CTRL_JAL_LINK_EN adds link_we/link_data (JAL return pc+8).
module fetch_controller (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        fetch_err
`ifdef FETCH_CTRL_JAL_LINK_EN
    ,
    output logic        link_we,
    output logic [31:0] link_data
`endif
);

    typedef enum logic [1:0] {BOOT, REQ, ISSUE, ERR} state_t;

    state_t      state, state_nx;
    logic [3:0]  wait_cnt, wait_nx;
    logic [31:0] pc_nx, instr_nx, pc_plus4;
    logic        consume, is_jump;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    // Opcodes 000010 (J) and 000011 (JAL) share the top five bits.
    assign is_jump   = (instr[31:27] == 5'b00001);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= 32'd0;
            instr    <= 32'd0;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            instr    <= instr_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        pc_nx       = pc;
        instr_nx    = instr;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        consume     = 1'b0;
        unique case (state)
            BOOT: begin
                state_nx = REQ;
                wait_nx  = 4'd0;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_nx = imem_rdata;
                    state_nx = ISSUE;
                end else begin
                    // Fifteenth unacknowledged cycle is a timeout.
                    wait_nx = wait_cnt + 4'd1;
                    if (wait_nx == 4'd15) begin
                        state_nx = ERR;
                    end
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    consume  = 1'b1;
                    state_nx = REQ;
                    wait_nx  = 4'd0;
                    if (branch_taken) begin
                        pc_nx = branch_target;
                    end else if (is_jump) begin
                        pc_nx = {pc_plus4[31:28], instr[25:0], 2'b00};
                    end else begin
                        pc_nx = pc_plus4;
                    end
                end
            end
            ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

`ifdef FETCH_CTRL_JAL_LINK_EN
    logic is_jal;
    assign is_jal = (instr[31:26] == 6'b000011);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            link_we   <= 1'b0;
            link_data <= 32'd0;
        end else begin
            link_we <= consume && is_jal;
            if (consume && is_jal) begin
                link_data <= pc + 32'd8;
            end
        end
    end
`else
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: scoreboard queues of expected
// fetch addresses and instruction words, one task per scenario.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;
`ifdef FETCH_CTRL_JAL_LINK_EN
    logic        link_we;
    logic [31:0] link_data;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_ins[$];
    logic [31:0] m_pc;
    logic [31:0] m_ins;

    fetch_controller dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .pc(pc),
        .instr(instr),
        .instr_valid(instr_valid),
        .fetch_err(fetch_err)
`ifdef FETCH_CTRL_JAL_LINK_EN
        ,
        .link_we(link_we),
        .link_data(link_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        stall = 1'b1;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_addr.delete();
        exp_ins.delete();
        m_pc = 32'd0;
        m_ins = 32'd0;
        exp_addr.push_back(32'd0);
    endtask

    // Wait for a request, hold ack off dly cycles, then return the word.
    task automatic fetch(input logic [31:0] d, input int dly,
                         output logic [31:0] a, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        a = 'x;
        while (!imem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!imem_req) return;
        a = imem_addr;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        imem_ack = 1'b1;
        imem_rdata = d;
        m_ins = d;
        exp_ins.push_back(d);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        ok = instr_valid;
    endtask

    task automatic consume(input bit bt, input logic [31:0] tgt);
        logic [31:0] p4;
        p4 = m_pc + 32'd4;
        if (bt) m_pc = tgt;
        else if (m_ins[31:26] == 6'b000010 || m_ins[31:26] == 6'b000011)
            m_pc = {p4[31:28], m_ins[25:0], 2'b00};
        else m_pc = p4;
        exp_addr.push_back(m_pc);
        stall = 1'b0;
        branch_taken = bt;
        branch_target = tgt;
        @(posedge clk);
        #1;
        stall = 1'b1;
        branch_taken = 1'b0;
        branch_target = $urandom;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if ({imem_req, instr_valid, fetch_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 000",
                     {imem_req, instr_valid, fetch_err});
        end
        vectors++;
        if (pc !== 32'd0 || instr !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got pc %h instr %h want 0 0", pc, instr);
        end
        do_reset();
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_req: got %b want 0", imem_req);
        end
    endtask

    task automatic test_first_fetch();
        logic [31:0] a, ea, ei;
        bit ok;
        fetch(32'h2402_0001, 2, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'd0) begin
            miscompares++;
            $display("FAIL first_addr: got %h want %h", a, ea);
        end
        vectors++;
        if (!ok || instr !== ei || imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL first_issue: got v%b req%b %h want v1 req0 %h",
                     ok, imem_req, instr, ei);
        end
        consume(1'b0, 32'd0);
        vectors++;
        if (imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL consume_req: got %b want 1", imem_req);
        end
        fetch(32'h0000_0013, 0, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'h4 || !ok || instr !== ei) begin
            miscompares++;
            $display("FAIL second_fetch: got %h/%h want 00000004/%h", a, instr, ei);
        end
    endtask

    task automatic test_jump();
        logic [31:0] a, ea, ei;
        bit ok;
        consume(1'b1, 32'h1000_0010);
        fetch(32'h0800_0040, 1, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || !ok || instr !== ei || pc !== 32'h1000_0010) begin
            miscompares++;
            $display("FAIL branch_fetch: got %h pc %h want %h", a, pc, ea);
        end
        consume(1'b0, 32'd0);
        fetch(32'h0000_0013, 0, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'h1000_0100 || !ok || instr !== ei) begin
            miscompares++;
            $display("FAIL j_target: got %h want 10000100", a);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, ea, ei;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            branch_target = 32'h0000_0500;
            imem_ack = (i == 2);
            imem_rdata = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            vectors++;
            if (pc !== m_pc || instr !== m_ins || instr_valid !== 1'b1 ||
                imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold%0d: got %h/%h v%b want %h/%h v1",
                         i, pc, instr, instr_valid, m_pc, m_ins);
            end
        end
        branch_taken = 1'b0;
        imem_ack = 1'b0;
        consume(1'b1, 32'h0000_0200);
        fetch(32'h0000_0013, 0, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'h0000_0200 || !ok || instr !== ei) begin
            miscompares++;
            $display("FAIL stall_branch: got %h want 00000200", a);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a, ea, ei;
        bit ok;
        consume(1'b1, 32'hFFFF_FFFC);
        fetch(32'h0000_0013, 0, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || !ok || instr !== ei) begin
            miscompares++;
            $display("FAIL wrap_pre: got %h want %h", a, ea);
        end
        consume(1'b0, 32'd0);
        fetch(32'h0C00_0100, 0, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'h0 || !ok || instr !== ei) begin
            miscompares++;
            $display("FAIL wrap: got %h want 00000000", a);
        end
    endtask

    task automatic test_jal();
        logic [31:0] a, ea, ei;
        bit ok;
        consume(1'b1, 32'h0000_0040);
        fetch(32'h0C00_0100, 0, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'h40 || !ok || instr !== ei) begin
            miscompares++;
            $display("FAIL jal_fetch: got %h want 00000040", a);
        end
        consume(1'b0, 32'd0);
`ifdef FETCH_CTRL_JAL_LINK_EN
        vectors++;
        if (link_we !== 1'b1 || link_data !== 32'h48) begin
            miscompares++;
            $display("FAIL link: got we%b %h want we1 00000048", link_we, link_data);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (link_we !== 1'b0) begin
            miscompares++;
            $display("FAIL link_pulse: got %b want 0", link_we);
        end
`endif
        fetch(32'h0000_0013, 14, a, ok);
        ea = exp_addr.pop_front();
        ei = exp_ins.pop_front();
        vectors++;
        if (a !== ea || a !== 32'h400) begin
            miscompares++;
            $display("FAIL jal_target: got %h want 00000400", a);
        end
        vectors++;
        if (!ok || instr !== ei || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL late_ack14: got v%b err%b want v1 err0", ok, fetch_err);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] ea;
        consume(1'b0, 32'd0);
        ea = exp_addr.pop_front();
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== ea) begin
            miscompares++;
            $display("FAIL to_req: got %b %h want 1 %h", imem_req, imem_addr, ea);
        end
        repeat (14) @(posedge clk);
        #1;
        vectors++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL to_early: got err%b req%b want err0 req1",
                     fetch_err, imem_req);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL to_err: got err%b req%b v%b want err1 req0 v0",
                     fetch_err, imem_req, instr_valid);
        end
        imem_ack = 1'b1;
        stall = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        imem_ack = 1'b0;
        stall = 1'b1;
        vectors++;
        if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: got err%b req%b v%b want 1 0 0",
                     fetch_err, imem_req, instr_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got %b want 0", fetch_err);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, ea;
        bit ok;
        fetch(32'h1234_5678, 0, a, ok);
        ea = exp_addr.pop_front();
        void'(exp_ins.pop_front());
        vectors++;
        if (a !== ea || !ok) begin
            miscompares++;
            $display("FAIL mid_fetch: got %h v%b want %h v1", a, ok, ea);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || pc !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_issue_rst: got v%b %h want v0 0", instr_valid, instr);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBADC_0DE0;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_req_rst: got %b want 0", imem_req);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        vectors++;
        if (instr !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            imem_addr !== 32'd0) begin
            miscompares++;
            $display("FAIL late_ack: got %h v%b req%b @%h want 0 v0 req1 @0",
                     instr, instr_valid, imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_jump();
        test_stall();
        test_wrap();
        test_jal();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-004 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-005 SHALL have port imem_ack  input  1  memory read-data-valid strobe.
REQ-006 SHALL have port imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-007 SHALL have port stall  input  1  downstream not ready; holds the issued instruction.
REQ-008 SHALL have port branch_taken  input  1  redirect request from execute stage.
REQ-009 SHALL have port branch_target  input  32  redirect address, used when branch_taken=1.
REQ-010 SHALL have port pc  output  32  address of the current instruction.
REQ-011 SHALL have port instr  output  32  latched instruction word.
REQ-012 SHALL have port instr_valid  output  1  instr is valid and offered downstream.
REQ-013 SHALL have port fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-014 SHALL implement FSM states BOOT, REQ, ISSUE, ERR.
REQ-015 BOOT: imem_req=0; SHALL go to REQ on the first clock edge after reset deasserts.
REQ-016 REQ: imem_req=1, imem_addr=pc; on imem_ack=1 SHALL latch imem_rdata into instr and go to ISSUE.
REQ-017 REQ: SHALL count wait cycles with a 4-bit counter cleared on REQ entry; counter reaching 15 without ack SHALL go to ERR.
REQ-018 ISSUE: instr_valid=1, imem_req=0; with stall=1, pc and instr SHALL hold and state SHALL remain ISSUE.
REQ-019 ISSUE with stall=0 SHALL update pc and go to REQ in the same edge; instruction is consumed exactly once.
REQ-020 Next-pc priority on consume: branch_taken=1 -> branch_target; else J/JAL (instr[31:26]=6'b000010 or 6'b000011) -> {pc_plus4[31:28], instr[25:0], 2'b00}; else pc+4.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 branch_taken while stall=1 or outside ISSUE SHALL be ignored.
REQ-023 ERR: imem_req=0, instr_valid=0, fetch_err=1; state SHALL remain ERR until reset.
REQ-024 imem_ack outside REQ SHALL be ignored.
REQ-025 Latency: ack to instr_valid = 1 cycle; consume to next imem_req = 1 cycle.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force state=BOOT, pc=0, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0.
REQ-027 reset asserted mid-REQ or mid-ISSUE SHALL abandon the fetch; a late imem_ack SHALL NOT be captured.

Configuration
REQ-028 Macro FETCH_CTRL_JAL_LINK_EN defined: SHALL add outputs link_we (1) and link_data (32); on consume of JAL, link_we=1 for one cycle with link_data=pc+8; both reset to 0.
REQ-029 Macro FETCH_CTRL_JAL_LINK_EN undefined: link_we/link_data SHALL NOT exist; JAL SHALL behave as J.

Verification
REQ-030 Reset release, ack after 2 cycles with 32'h2402_0001 -> imem_addr=0, instr_valid=1 with instr=32'h2402_0001, next request at address 4.
REQ-031 pc=32'h1000_0010, instr=32'h0800_0040 consumed -> next pc=32'h1000_0100.
REQ-032 ISSUE with stall=1 for 3 cycles, branch_taken pulsed during stall -> pc/instr held, pulse ignored; stall=0 with branch_taken=1, target 32'h0000_0200 -> next imem_addr=32'h0000_0200.
REQ-033 REQ with no ack for 15 cycles -> fetch_err=1, imem_req=0 permanently; reset clears it.
REQ-034 pc=32'hFFFF_FFFC, non-jump consumed -> next imem_addr=32'h0000_0000.
REQ-035 With FETCH_CTRL_JAL_LINK_EN, JAL consumed at pc=32'h0000_0040 -> link_we=1 for one cycle, link_data=32'h0000_0048.
